// File: rtl/serial_deserializer_if.sv
// Serial-in/parallel-out bundle: bit stream, frame abort and the word handshake.
// The master drives the bits and ready_i. The slave is the deserializer, which returns the word and status.
interface serial_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             ser_i;
  logic             ser_valid_i;
  logic             dir_i;
  logic             abort_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             overrun_o;
  logic [CNT_W-1:0] bit_cnt_o;

  modport master (
    output ser_i, ser_valid_i, dir_i, abort_i, ready_i,
    input  data_o, valid_o, overrun_o, bit_cnt_o
  );

  modport slave (
    input  ser_i, ser_valid_i, dir_i, abort_i, ready_i,
    output data_o, valid_o, overrun_o, bit_cnt_o
  );
endinterface

// File: rtl/serial_deserializer.sv
// Assembles WIDTH-bit words from one qualified bit per clock and places each word in a one-entry valid/ready holding register.
// A word is visible 1 clock after its last bit. A word that completes while the register is full is dropped, and overrun_o is set.
module serial_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_deserializer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_chk
    $error("serial_deserializer: WIDTH must be >= 2");
  end
  if ((1 << CNT_W) < WIDTH) begin : g_cnt_chk
    $error("serial_deserializer: CNT_W too narrow for WIDTH");
  end

  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             dir_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;

  logic             dir_eff;
  logic             accept;
  logic             complete;
  logic             handshake;
  logic             load;
  logic             drop;
  logic [WIDTH-1:0] sreg_next;

  // The first bit of a word uses dir_i directly so that direction takes effect with no extra cycle.
  always_comb begin
    dir_eff   = (bit_cnt == '0) ? bus.dir_i : dir_q;
    accept    = bus.ser_valid_i && !bus.abort_i;
    sreg_next = dir_eff ? {bus.ser_i, sreg[WIDTH-1:1]}
                        : {sreg[WIDTH-2:0], bus.ser_i};
    complete  = accept && (bit_cnt == LAST_BIT);
    handshake = valid_q && bus.ready_i;
    load      = complete && (!valid_q || bus.ready_i);
    drop      = complete && valid_q && !bus.ready_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      dir_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (bus.abort_i) begin
        sreg      <= '0;
        bit_cnt   <= '0;
        overrun_q <= 1'b0;
      end else if (bus.ser_valid_i) begin
        sreg    <= sreg_next;
        bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
        if (bit_cnt == '0) begin
          dir_q <= bus.dir_i;
        end
      end

      if (drop) begin
        overrun_q <= 1'b1;
      end

      // The holding register keeps running during abort. Only the assembly side is flushed.
      if (load) begin
        data_q  <= sreg_next;
        valid_q <= 1'b1;
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_o    = data_q;
  assign bus.valid_o   = valid_q;
  assign bus.overrun_o = overrun_q;
  assign bus.bit_cnt_o = bit_cnt;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer. It applies directed vector tables, hand-written corner sequences and random traffic.
// A bit-queue reference model is checked on every cycle.
module tb_serial_deserializer;
  localparam int W  = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  serial_deserializer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  serial_deserializer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference model. It keeps the bits of the current word in arrival order.
  bit         mq[$];
  logic       m_dir;
  logic [W-1:0] m_data;
  logic       m_valid;
  logic       m_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] assemble();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (m_dir) w[i] = mq[i];
      else       w[W-1-i] = mq[i];
    end
    return w;
  endfunction

  task automatic model(input logic r, input logic s, input logic v, input logic d,
                       input logic a, input logic rd);
    logic nv;
    logic [W-1:0] w;
    if (!r) begin
      mq.delete();
      m_dir = 1'b0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      nv = m_valid && !rd;
      if (a) begin
        mq.delete();
        m_ovr = 1'b0;
      end else if (v) begin
        if (mq.size() == 0) m_dir = d;
        mq.push_back(s);
        if (mq.size() == W) begin
          w = assemble();
          mq.delete();
          if (!m_valid || rd) begin
            m_data = w;
            nv = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
      m_valid = nv;
    end
  endtask

  // Drives one cycle of inputs, clocks the design and model, then compares all outputs 1 time unit after the edge.
  task automatic step(input logic r, input logic s, input logic v, input logic d,
                      input logic a, input logic rd);
    rst_n = r;
    bus.ser_i = s; bus.ser_valid_i = v; bus.dir_i = d; bus.abort_i = a; bus.ready_i = rd;
    @(posedge clk);
    model(r, s, v, d, a, rd);
    #1;
    cyc++;
    chk("model_data",    32'(bus.data_o),    32'(m_data));
    chk("model_valid",   32'(bus.valid_o),   32'(m_valid));
    chk("model_overrun", 32'(bus.overrun_o), 32'(m_ovr));
    chk("model_bit_cnt", 32'(bus.bit_cnt_o), 32'(mq.size()));
  endtask

  task automatic idle(input logic rd);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rd);
  endtask

  // Sends vec[W-1] first. ready_i is rd on every bit except the last, which uses rd_last.
  task automatic send_bits(input logic [W-1:0] vec, input int n, input logic d,
                           input logic rd, input logic rd_last);
    for (int i = 0; i < n; i++)
      step(1'b1, vec[W-1-i], 1'b1, d, 1'b0, (i == n - 1) ? rd_last : rd);
  endtask

  typedef struct {
    logic         dir;
    logic [W-1:0] vec;   // bit W-1 is sent first
    logic         gap;   // idle cycle after every bit
    logic         flip;  // invert dir_i after the third bit
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    rst_n = 1'b0;
    bus.ser_i = 1'b0; bus.ser_valid_i = 1'b0; bus.dir_i = 1'b0;
    bus.abort_i = 1'b0; bus.ready_i = 1'b0;
    mq.delete();
    m_dir = 1'b0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;

    tbl[0] = '{dir:1'b0, vec:8'b1010_0101, gap:1'b0, flip:1'b0, exp:8'hA5};
    tbl[1] = '{dir:1'b1, vec:8'b1010_0101, gap:1'b0, flip:1'b0, exp:8'hA5};
    tbl[2] = '{dir:1'b1, vec:8'b1100_0000, gap:1'b0, flip:1'b0, exp:8'h03};
    tbl[3] = '{dir:1'b0, vec:8'h3C,        gap:1'b1, flip:1'b1, exp:8'h3C};
    tbl[4] = '{dir:1'b1, vec:8'b1000_0000, gap:1'b1, flip:1'b1, exp:8'h01};

    // Reset state.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_valid",   32'(bus.valid_o),   32'd0);
    chk("reset_data",    32'(bus.data_o),    32'd0);
    chk("reset_bit_cnt", 32'(bus.bit_cnt_o), 32'd0);

    // Table-driven words.
    foreach (tbl[k]) begin
      for (int i = 0; i < W; i++) begin
        logic d;
        d = (tbl[k].flip && i >= 3) ? ~tbl[k].dir : tbl[k].dir;
        step(1'b1, tbl[k].vec[W-1-i], 1'b1, d, 1'b0, 1'b1);
        if (tbl[k].gap && i < W - 1) begin
          idle(1'b1);
          chk("gap_bit_cnt_hold", 32'(bus.bit_cnt_o), 32'(i + 1));
        end
      end
      chk("tbl_valid",   32'(bus.valid_o),   32'd1);
      chk("tbl_data",    32'(bus.data_o),    32'(tbl[k].exp));
      chk("tbl_bit_cnt", 32'(bus.bit_cnt_o), 32'd0);
      idle(1'b1);
      chk("tbl_consumed", 32'(bus.valid_o), 32'd0);
    end

    // Backpressure: the second word is dropped and overrun_o stays set until abort.
    send_bits(8'h11, W, 1'b0, 1'b0, 1'b0);
    send_bits(8'h22, W, 1'b0, 1'b0, 1'b0);
    chk("ovr_data_kept", 32'(bus.data_o),    32'h11);
    chk("ovr_flag",      32'(bus.overrun_o), 32'd1);
    idle(1'b1);
    chk("ovr_valid_drop",  32'(bus.valid_o),   32'd0);
    chk("ovr_sticky",      32'(bus.overrun_o), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_abort_clear", 32'(bus.overrun_o), 32'd0);

    // Handshake in the same cycle the next word completes.
    send_bits(8'h11, W, 1'b0, 1'b0, 1'b0);
    send_bits(8'h22, W, 1'b0, 1'b0, 1'b1);
    chk("stream_valid", 32'(bus.valid_o),   32'd1);
    chk("stream_data",  32'(bus.data_o),    32'h22);
    chk("stream_ovr",   32'(bus.overrun_o), 32'd0);

    // Completion, overrun and abort in the same cycle: abort wins.
    send_bits(8'h22, W - 1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("abort_win_ovr",  32'(bus.overrun_o), 32'd0);
    chk("abort_win_data", 32'(bus.data_o),    32'h22);
    chk("abort_win_cnt",  32'(bus.bit_cnt_o), 32'd0);
    idle(1'b1);

    // Abort mid-word discards the partial word and the bit in the abort cycle.
    send_bits(8'hF8, 5, 1'b0, 1'b1, 1'b1);
    chk("mid_cnt5", 32'(bus.bit_cnt_o), 32'd5);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("mid_abort_cnt", 32'(bus.bit_cnt_o), 32'd0);
    send_bits(8'hC3, W, 1'b0, 1'b1, 1'b1);
    chk("mid_after_abort", 32'(bus.data_o), 32'hC3);

    // Reset while a word is held.
    send_bits(8'h5A, W, 1'b0, 1'b0, 1'b0);
    send_bits(8'h0F, 3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", 32'(bus.valid_o),   32'd0);
    chk("rst_data",  32'(bus.data_o),    32'd0);
    chk("rst_cnt",   32'(bus.bit_cnt_o), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) != 0), 1'($urandom), ($urandom_range(9) < 7),
           1'($urandom), ($urandom_range(39) == 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Serial-in/parallel-out receiver for bitstreams produced by the team's shift-register-with-parallel-load block running in shift mode.
- Accepts one qualified bit per clock and assembles WIDTH-bit words in either shift direction.
- Hands each completed word to a downstream consumer through a one-entry holding register with valid/ready handshake.
- Reports overruns and supports frame abort.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- CNT_W, 3, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- ser_i  input  1  serial data bit.
- ser_valid_i  input  1  ser_i is valid this cycle; one bit consumed per asserted cycle.
- dir_i  input  1  0 = MSB-first (new bit enters at LSB, word shifts left); 1 = LSB-first (new bit enters at MSB, word shifts right).
- abort_i  input  1  discards the partially assembled word and clears overrun_o.
- data_o  output  WIDTH  completed word in holding register.
- valid_o  output  1  data_o holds an unconsumed word.
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
- overrun_o  output  1  sticky: a completed word was dropped.
- bit_cnt_o  output  CNT_W  number of bits assembled in the current word (0..WIDTH-1).

Behaviour:
- Reset (rst_n=0 at clock edge):
  - shift register, data_o, valid_o, overrun_o, bit_cnt_o all 0.
  - Reset overrides every other input in that cycle.
  - Reset mid-word discards the partial word.
- Direction latch:
  - dir_i is sampled only on a valid bit accepted while bit_cnt_o == 0, into an internal dir register.
  - All remaining bits of that word use the latched direction.
  - dir_i changes mid-word have no effect.
- Shift on ser_valid_i=1:
  - dir=0: sreg <= {sreg[WIDTH-2:0], ser_i}.
  - dir=1: sreg <= {ser_i, sreg[WIDTH-1:1]}.
  - bit_cnt_o increments by 1.
  - ser_valid_i=0: sreg and bit_cnt_o hold.
- Word completion, on a valid bit with bit_cnt_o == WIDTH-1:
  - The completed word is the shifted value including the current bit.
  - bit_cnt_o wraps to 0 and the next cycle begins a new word.
  - No gap cycle is required between words.
- Holding register:
  - If valid_o==0, or valid_o && ready_i in the same cycle: data_o <= completed word and valid_o <= 1 on the next edge.
  - Latency is 1 clock from the last bit's edge to valid_o high.
  - If valid_o && !ready_i: the completed word is dropped, data_o is unchanged, overrun_o <= 1.
  - Handshake without a new completion: valid_o <= 0; data_o holds its stale value.
  - valid_o stays high, with data_o stable, until a handshake occurs.
- Abort (abort_i=1, rst_n=1):
  - bit_cnt_o <= 0, sreg <= 0, overrun_o <= 0.
  - The holding register and valid_o are unaffected, and handshakes proceed normally.
  - A ser_valid_i bit arriving in the same cycle is discarded; abort has priority.
- Simultaneous completion + handshake: the consumed word leaves and the new word loads; valid_o stays 1.
- Simultaneous completion + overrun + abort: abort wins; no word is captured and overrun_o ends at 0.
- Control structure: two states tracked by the bit counter, ASSEMBLE (bit_cnt 0..WIDTH-1) and a holding-register FULL/EMPTY flag. There is no other FSM state.

Test Plan:
- Reset then MSB-first load: dir_i=0, bits 1,0,1,0,0,1,0,1 on consecutive cycles with ready_i=1 -> valid_o=1 one cycle after the 8th bit, data_o=8'hA5, bit_cnt_o=0.
- LSB-first load: dir_i=1, same bit sequence -> data_o=8'hA5 reversed = 8'hA5 (palindrome check). Then send 1,1,0,0,0,0,0,0 -> data_o=8'h03.
- Gapped input and direction lock: ser_valid_i toggled every other cycle, dir_i flipped after the 3rd bit, sending 8'h3C MSB-first -> data_o=8'h3C, and bit_cnt_o holds during gaps.
- Backpressure/overrun: ready_i=0; send 8'h11 then 8'h22 back-to-back -> data_o stays 8'h11, overrun_o=1 after the 16th bit. Then ready_i=1 -> valid_o drops after handshake and overrun_o stays 1 until abort_i pulse.
- Streaming with handshake on completion: ready_i asserted exactly in the cycle the second word completes -> no overrun, data_o goes 8'h11 -> 8'h22 with valid_o continuously 1.
- Abort and reset mid-word: 5 bits sent, abort_i=1 with ser_valid_i=1 -> bit_cnt_o=0 and the bit is ignored. Repeat with rst_n=0 while valid_o=1 -> all outputs 0 next cycle.
